mb_rtu_resp: RTL and testbench

Modbus RTU slave response sequencer. Sits after `mb_rtu`, the frame receiver and CRC checker.

- Accepts a completed request frame and validates it.
- Builds either the normal function-0x10 (write multiple registers) echo response or an exception response.
- Appends the CRC-16.
- Drives `uart_tx` byte by byte over its `send_en`/`tx_done` handshake, after the RTU turnaround gap.

---
 rtl/mb_pkg.sv | 27 ++
 rtl/mb_crc16.sv | 46 ++++
 rtl/mb_rtu_resp.sv | 186 ++++++++++++++++++
 tb/tb_mb_rtu_resp.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mb_pkg.sv
// Shared Modbus RTU constants, response FSM states and the CRC-16/Modbus bit step.
package mb_pkg;

   localparam logic [7:0]  FC_WRITE_MULTI   = 8'h10;
   localparam logic [7:0]  EX_ILLEGAL_FUNC  = 8'h01;
   localparam logic [7:0]  EX_ILLEGAL_ADDR  = 8'h02;
   localparam logic [7:0]  EX_ILLEGAL_VALUE = 8'h03;
   localparam logic [15:0] MB_MAX_WRITE     = 16'd123;

   localparam logic [15:0] CRC_INIT = 16'hFFFF;
   localparam logic [15:0] CRC_POLY = 16'hA001;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_CRC,
      ST_GAP,
      ST_SEND,
      ST_WAIT,
      ST_DROP
   } state_t;

   function automatic logic [15:0] crc_step(input logic [15:0] c);
      return c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
   endfunction

endpackage

// File: rtl/mb_crc16.sv
// Bit-serial CRC-16/Modbus engine: one byte per 8 cycles, the first bit is
// processed in the cycle the byte is accepted.
module mb_crc16
   import mb_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        init,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [15:0] crc_out,
   output logic        ready
);

   logic [15:0] crc_q, crc_d;
   logic [2:0]  bit_q, bit_d;

   always_comb begin
      crc_d = crc_q;
      bit_d = bit_q;
      if (init) begin
         crc_d = CRC_INIT;
         bit_d = 3'd0;
      end else if (byte_valid && (bit_q == 3'd0)) begin
         crc_d = crc_step(crc_q ^ {8'h00, byte_in});
         bit_d = 3'd7;
      end else if (bit_q != 3'd0) begin
         crc_d = crc_step(crc_q);
         bit_d = bit_q - 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_q <= CRC_INIT;
         bit_q <= 3'd0;
      end else begin
         crc_q <= crc_d;
         bit_q <= bit_d;
      end
   end

   assign crc_out = crc_q;
   assign ready   = (bit_q == 3'd0);

endmodule

// File: rtl/mb_rtu_resp.sv
// Modbus RTU slave response sequencer: validates a received request, builds the
// function 0x10 echo or an exception reply, appends CRC-16 and streams it to uart_tx.
module mb_rtu_resp
   import mb_pkg::*;
#(
   parameter logic [7:0]  SLAVE_ADDR = 8'h01,
   parameter logic [15:0] REG_DEPTH  = 16'd64,
   parameter int          TURN_CYC   = 10000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_done,
   input  logic        crc_err,
   input  logic [7:0]  rx_addr,
   input  logic [7:0]  rx_func,
   input  logic [15:0] mb_reg,
   input  logic [15:0] mb_num,
   output logic        send_en,
   output logic [7:0]  data_byte,
   input  logic        tx_done,
   output logic        busy,
   output logic        resp_done,
   output logic        overrun
);

   localparam int CRC_MAX = 1 + 8 * 6;
   localparam int CNT_MAX = (TURN_CYC > CRC_MAX) ? TURN_CYC : CRC_MAX;
   localparam int CW      = $clog2(CNT_MAX + 1);

   state_t        state_q, state_d;
   logic [7:0]    addr_q, addr_d, func_q, func_d;
   logic [15:0]   reg_q, reg_d, num_q, num_d;
   logic          crc_err_q, crc_err_d;
   logic [7:0]    buf_q [8];
   logic [7:0]    buf_d [8];
   logic [2:0]    len_q, len_d, idx_q, idx_d, feed_q, feed_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          resp_done_q, resp_done_d;
   logic          crc_init, crc_valid, crc_ready;
   logic [15:0]   crc_val;
   logic          gap_done, crc_last;
   logic [7:0]    ex_code;
   logic [16:0]   reg_end;

   mb_crc16 u_crc (
      .clk        (clk),
      .rst_n      (rst_n),
      .init       (crc_init),
      .byte_valid (crc_valid),
      .byte_in    (buf_q[feed_q]),
      .crc_out    (crc_val),
      .ready      (crc_ready)
   );

   // cnt_q equals the number of cycles since frame_done, so it also marks the last CRC bit.
   assign gap_done = (cnt_q >= CW'(TURN_CYC));
   assign crc_last = (feed_q == len_q) && (cnt_q == CW'({len_q, 3'b001}));
   assign reg_end  = {1'b0, reg_q} + {1'b0, num_q};

   always_comb begin
      if (func_q != FC_WRITE_MULTI)                    ex_code = EX_ILLEGAL_FUNC;
      else if (num_q == 16'd0 || num_q > MB_MAX_WRITE) ex_code = EX_ILLEGAL_VALUE;
      else if (reg_end > {1'b0, REG_DEPTH})            ex_code = EX_ILLEGAL_ADDR;
      else                                             ex_code = 8'h00;
   end

   always_comb begin
      // NOTE: every signal written here gets its default first, so no path infers a latch.
      state_d     = state_q;
      addr_d      = addr_q;
      func_d      = func_q;
      reg_d       = reg_q;
      num_d       = num_q;
      crc_err_d   = crc_err_q;
      buf_d       = buf_q;
      len_d       = len_q;
      idx_d       = idx_q;
      feed_d      = feed_q;
      cnt_d       = cnt_q;
      resp_done_d = 1'b0;
      crc_init    = 1'b0;
      crc_valid   = 1'b0;

      if (state_q != ST_IDLE && cnt_q != CW'(CNT_MAX)) cnt_d = cnt_q + CW'(1);

      case (state_q)
         ST_IDLE: if (frame_done) begin
            addr_d    = rx_addr;
            func_d    = rx_func;
            reg_d     = mb_reg;
            num_d     = mb_num;
            crc_err_d = crc_err;
            cnt_d     = CW'(1);
            state_d   = ST_CHECK;
         end
         ST_CHECK: begin
            crc_init = 1'b1;
            feed_d   = 3'd0;
            idx_d    = 3'd0;
            // A broadcast (addr 0) also mismatches SLAVE_ADDR: it is never answered.
            if (crc_err_q || addr_q != SLAVE_ADDR) begin
               state_d = ST_DROP;
            end else begin
               state_d  = ST_CRC;
               buf_d[0] = addr_q;
               if (ex_code == 8'h00) begin
                  buf_d[1] = FC_WRITE_MULTI;
                  buf_d[2] = reg_q[15:8];
                  buf_d[3] = reg_q[7:0];
                  buf_d[4] = num_q[15:8];
                  buf_d[5] = num_q[7:0];
                  len_d    = 3'd6;
               end else begin
                  buf_d[1] = func_q | 8'h80;
                  buf_d[2] = ex_code;
                  len_d    = 3'd3;
               end
            end
         end
         ST_CRC: begin
            crc_valid = crc_ready && (feed_q != len_q);
            if (crc_valid) feed_d = feed_q + 3'd1;
            if (crc_last) state_d = gap_done ? ST_SEND : ST_GAP;
         end
         ST_GAP:  if (gap_done) state_d = ST_SEND;
         ST_SEND: state_d = ST_WAIT;
         ST_WAIT: if (tx_done) begin
            if (idx_q == len_q + 3'd1) begin
               resp_done_d = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               idx_d   = idx_q + 3'd1;
               state_d = ST_SEND;
            end
         end
         ST_DROP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (state_q == ST_GAP || state_q == ST_SEND || state_q == ST_WAIT) begin
         buf_d[len_q]        = crc_val[7:0];
         buf_d[len_q + 3'd1] = crc_val[15:8];
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= 8'h00;
         func_q      <= 8'h00;
         reg_q       <= 16'h0000;
         num_q       <= 16'h0000;
         crc_err_q   <= 1'b0;
         len_q       <= 3'd0;
         idx_q       <= 3'd0;
         feed_q      <= 3'd0;
         cnt_q       <= '0;
         resp_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         func_q      <= func_d;
         reg_q       <= reg_d;
         num_q       <= num_d;
         crc_err_q   <= crc_err_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         feed_q      <= feed_d;
         cnt_q       <= cnt_d;
         resp_done_q <= resp_done_d;
      end
   end

   // NOTE: the buffer is not reset; it is always rewritten in CHECK and data_byte is gated outside SEND/WAIT.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   assign send_en   = (state_q == ST_SEND);
   assign data_byte = (state_q == ST_SEND || state_q == ST_WAIT) ? buf_q[idx_q] : 8'h00;
   assign busy      = (state_q != ST_IDLE);
   assign resp_done = resp_done_q;
   assign overrun   = frame_done && busy;

endmodule

// File: tb/tb_mb_rtu_resp.sv
// Scoreboard bench for mb_rtu_resp: a uart_tx model pops expected bytes on each
// send_en and answers with tx_done; scenario tasks check framing, timing and drops.
module tb_mb_rtu_resp;

   localparam logic [7:0]  SLAVE  = 8'h01;
   localparam logic [15:0] DEPTH  = 16'd64;
   localparam int          TURN   = 100;
   localparam int          TX_LEN = 6;

   logic        clk, rst_n, frame_done, crc_err, tx_done;
   logic [7:0]  rx_addr, rx_func, data_byte;
   logic [15:0] mb_reg, mb_num;
   logic        send_en, busy, resp_done, overrun;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int fd_cyc = 0;
   int first_send_cyc = 0;
   int n_sent_frame = 0;
   int n_txd_frame = 0;
   int resp_cnt = 0;
   logic [7:0] exp_q [$];

   mb_rtu_resp #(
      .SLAVE_ADDR (SLAVE),
      .REG_DEPTH  (DEPTH),
      .TURN_CYC   (TURN)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_done (frame_done),
      .crc_err    (crc_err),
      .rx_addr    (rx_addr),
      .rx_func    (rx_func),
      .mb_reg     (mb_reg),
      .mb_num     (mb_num),
      .send_en    (send_en),
      .data_byte  (data_byte),
      .tx_done    (tx_done),
      .busy       (busy),
      .resp_done  (resp_done),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] crc16_model(input logic [7:0] b [8], input int n);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {8'h00, b[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return c;
   endfunction

   // uart_tx model and scoreboard consumer
   initial begin : uart_model
      logic [7:0] tx_byte;
      logic [7:0] e;
      int left;
      bit active;
      tx_done = 1'b0;
      active  = 1'b0;
      left    = 0;
      tx_byte = 8'h00;
      forever begin
         @(negedge clk);
         tx_done = 1'b0;
         if (rst_n !== 1'b1) begin
            active = 1'b0;
         end else if (active) begin
            n_tests++;
            if (data_byte !== tx_byte || send_en !== 1'b0) begin
               n_fail++;
               $display("FAIL data_byte_hold: data_byte=%h send_en=%b, want %h and 0", data_byte, send_en, tx_byte);
            end
            left--;
            if (left == 0) begin
               tx_done = 1'b1;
               active  = 1'b0;
               n_txd_frame++;
            end
         end else if (send_en === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_send_en: data_byte=%h, no byte expected", data_byte);
            end else begin
               e = exp_q.pop_front();
               if (data_byte !== e) begin
                  n_fail++;
                  $display("FAIL resp_byte%0d: got %h, want %h", n_sent_frame, data_byte, e);
               end
            end
            if (n_sent_frame == 0) first_send_cyc = cyc;
            n_sent_frame++;
            tx_byte = data_byte;
            active  = 1'b1;
            left    = TX_LEN;
         end
      end
   end

   initial begin : done_monitor
      forever begin
         @(negedge clk);
         if (resp_done === 1'b1) begin
            resp_cnt++;
            n_tests++;
            if (busy !== 1'b0) begin
               n_fail++;
               $display("FAIL busy_at_resp_done: got %b, want 0", busy);
            end
         end
      end
   end

   task automatic send_req(input logic [7:0] a, input logic [7:0] f,
                           input logic [15:0] r, input logic [15:0] n, input logic ce);
      @(negedge clk);
      n_sent_frame = 0;
      n_txd_frame  = 0;
      rx_addr = a; rx_func = f; mb_reg = r; mb_num = n; crc_err = ce;
      frame_done = 1'b1;
      fd_cyc = cyc;
      @(negedge clk);
      frame_done = 1'b0;
      rx_addr = ~a; rx_func = ~f; mb_reg = ~r; mb_num = ~n; crc_err = ~ce;
   endtask

   task automatic push_expected(input logic [7:0] pre [6], input int len);
      logic [7:0]  b [8];
      logic [15:0] c;
      for (int i = 0; i < 8; i++) b[i] = 8'h00;
      for (int i = 0; i < len; i++) b[i] = pre[i];
      c = crc16_model(b, len);
      for (int i = 0; i < len; i++) exp_q.push_back(b[i]);
      exp_q.push_back(c[7:0]);
      exp_q.push_back(c[15:8]);
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (busy === 1'b1 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_timeout: busy=%b after %0d cycles, want 0", name, busy, k);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic check_done(input string name, input int len, input int rd0);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_bytes_left: %0d left, want 0", name, exp_q.size());
      end
      n_tests++;
      if (n_sent_frame != len + 2) begin
         n_fail++;
         $display("FAIL %s_byte_count: got %0d, want %0d", name, n_sent_frame, len + 2);
      end
      n_tests++;
      if (resp_cnt != rd0 + 1) begin
         n_fail++;
         $display("FAIL %s_resp_done_count: got %0d, want %0d", name, resp_cnt - rd0, 1);
      end
      exp_q.delete();
   endtask

   task automatic run_resp(input string name, input logic [7:0] a, input logic [7:0] f,
                           input logic [15:0] r, input logic [15:0] n,
                           input logic [7:0] pre [6], input int len);
      int rd0;
      int exp_first;
      exp_first = ((TURN > 1 + 8 * len) ? TURN : 1 + 8 * len) + 1;
      push_expected(pre, len);
      rd0 = resp_cnt;
      send_req(a, f, r, n, 1'b0);
      wait_idle(name);
      check_done(name, len, rd0);
      n_tests++;
      if (first_send_cyc - fd_cyc != exp_first) begin
         n_fail++;
         $display("FAIL %s_first_send: got cycle %0d, want %0d", name, first_send_cyc - fd_cyc, exp_first);
      end
   endtask

   task automatic drop_case(input string name, input logic [7:0] a, input logic ce);
      int rd0;
      int bc;
      rd0 = resp_cnt;
      send_req(a, 8'h10, 16'h0000, 16'h0002, ce);
      bc = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy === 1'b1) bc++;
         @(negedge clk);
      end
      n_tests++;
      if (bc != 2) begin
         n_fail++;
         $display("FAIL %s_busy_cycles: got %0d, want 2", name, bc);
      end
      repeat (TURN + 20) @(negedge clk);
      n_tests++;
      if (n_sent_frame != 0 || resp_cnt != rd0) begin
         n_fail++;
         $display("FAIL %s_silent: sent %0d resp_done %0d, want 0 and 0", name, n_sent_frame, resp_cnt - rd0);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      frame_done = 1'b0; crc_err = 1'b0;
      rx_addr = 8'h00; rx_func = 8'h00; mb_reg = 16'h0000; mb_num = 16'h0000;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({send_en, data_byte, busy, resp_done, overrun} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h, want 000", {send_en, data_byte, busy, resp_done, overrun});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_valid_write();
      run_resp("valid_write", 8'h01, 8'h10, 16'h0000, 16'h0002,
               '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02}, 6);
   endtask

   task automatic test_drops();
      drop_case("bad_crc",    8'h01, 1'b1);
      drop_case("wrong_addr", 8'h05, 1'b0);
      drop_case("broadcast",  8'h00, 1'b0);
   endtask

   task automatic test_exceptions();
      run_resp("ex_func", 8'h01, 8'h03, 16'h0000, 16'h0002,
               '{8'h01, 8'h83, 8'h01, 8'h00, 8'h00, 8'h00}, 3);
      run_resp("ex_addr", 8'h01, 8'h10, 16'h003F, 16'h0002,
               '{8'h01, 8'h90, 8'h02, 8'h00, 8'h00, 8'h00}, 3);
      run_resp("ex_num0", 8'h01, 8'h10, 16'h0000, 16'h0000,
               '{8'h01, 8'h90, 8'h03, 8'h00, 8'h00, 8'h00}, 3);
   endtask

   task automatic test_boundaries();
      run_resp("top_reg", 8'h01, 8'h10, 16'h003E, 16'h0002,
               '{8'h01, 8'h10, 8'h00, 8'h3E, 8'h00, 8'h02}, 6);
      run_resp("num_124", 8'h01, 8'h10, 16'h0000, 16'd124,
               '{8'h01, 8'h90, 8'h03, 8'h00, 8'h00, 8'h00}, 3);
      run_resp("num_123", 8'h01, 8'h10, 16'h0000, 16'd123,
               '{8'h01, 8'h90, 8'h02, 8'h00, 8'h00, 8'h00}, 3);
   endtask

   task automatic test_overrun();
      int rd0;
      int k;
      push_expected('{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02}, 6);
      rd0 = resp_cnt;
      send_req(8'h01, 8'h10, 16'h0000, 16'h0002, 1'b0);
      k = 0;
      while (n_sent_frame < 3 && k < 2000) begin
         @(negedge clk);
         #1;
         k++;
      end
      n_tests++;
      if (n_sent_frame < 3) begin
         n_fail++;
         $display("FAIL overrun_wait_byte3: sent %0d, want 3", n_sent_frame);
      end
      rx_addr = 8'h01; rx_func = 8'h03; mb_reg = 16'h0005; mb_num = 16'h0001; crc_err = 1'b0;
      frame_done = 1'b1;
      #1;
      n_tests++;
      if (overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_pulse: got %b, want 1", overrun);
      end
      @(negedge clk);
      frame_done = 1'b0;
      #1;
      n_tests++;
      if (overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_clear: got %b, want 0", overrun);
      end
      wait_idle("overrun");
      check_done("overrun", 6, rd0);
   endtask

   task automatic test_reset_mid();
      int k;
      push_expected('{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02}, 6);
      send_req(8'h01, 8'h10, 16'h0000, 16'h0002, 1'b0);
      k = 0;
      while (n_txd_frame < 4 && k < 2000) begin
         @(negedge clk);
         #1;
         k++;
      end
      n_tests++;
      if (n_txd_frame != 4) begin
         n_fail++;
         $display("FAIL reset_mid_wait: tx_done count %0d, want 4", n_txd_frame);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({send_en, data_byte, busy, resp_done, overrun} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got %h, want 000", {send_en, data_byte, busy, resp_done, overrun});
      end
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (TURN + 20) @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_resumed: busy=%b, want 0", busy);
      end
      run_resp("after_reset", 8'h01, 8'h10, 16'h0000, 16'h0002,
               '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02}, 6);
   endtask

   initial begin
      test_reset();
      test_valid_write();
      test_drops();
      test_exceptions();
      test_boundaries();
      test_overrun();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
